// File: rtl/ins_cache_nway.sv
// N-way set-associative instruction cache tag model with true LRU ages,
// sequential flush, multi-cycle line fill handshake and saturating statistics.
module ins_cache_nway #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned OFFSET_BITS = 6,
  parameter int unsigned INDEX_BITS  = 14,
  parameter int unsigned WAYS        = 4,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [3:0]                    n,
  input  logic [ADDR_W-1:0]             add_in,
  output logic                          rsp_valid,
  output logic                          rsp_hit,
  output logic                          mem_req,
  output logic [ADDR_W-OFFSET_BITS-1:0] mem_addr,
  input  logic                          mem_ack,
  output logic [CNT_W-1:0]              hits,
  output logic [CNT_W-1:0]              misses,
  output logic [CNT_W-1:0]              reads,
  output logic [CNT_W-1:0]              evictions
);

  localparam int unsigned TAG_W  = ADDR_W - INDEX_BITS - OFFSET_BITS;
  localparam int unsigned AGE_W  = $clog2(WAYS);
  localparam int unsigned LINE_W = ADDR_W - OFFSET_BITS;
  localparam int unsigned SETS   = 1 << INDEX_BITS;

  typedef logic [WAYS-1:0][AGE_W-1:0] ages_t;
  typedef logic [WAYS-1:0][TAG_W-1:0] tags_t;
  typedef enum logic [2:0] {ST_FLUSH, ST_IDLE, ST_LOOKUP, ST_MISS_REQ, ST_FILL} state_e;

  state_e                  state_q, state_d;
  logic [INDEX_BITS-1:0]   ptr_q, ptr_d;
  logic [3:0]              cmd_n_q, cmd_n_d;
  logic [LINE_W-1:0]       line_q, line_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_hit_q, rsp_hit_d;
  logic                    mem_req_q, mem_req_d;
  logic [LINE_W-1:0]       mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]        hits_q, hits_d, misses_q, misses_d;
  logic [CNT_W-1:0]        reads_q, reads_d, evict_q, evict_d;

  logic [WAYS-1:0]         valid_q [SETS];
  tags_t                   tag_q   [SETS];
  ages_t                   age_q   [SETS];

  logic [INDEX_BITS-1:0]   idx_c;
  logic [TAG_W-1:0]        tag_c;
  logic [WAYS-1:0]         rd_valid_c;
  tags_t                   rd_tag_c;
  ages_t                   rd_age_c;
  ages_t                   age_init_c;
  logic                    hit_c, vic_free_c;
  logic [AGE_W-1:0]        hit_way_c, vic_way_c;
  logic                    set_we_d;
  logic [WAYS-1:0]         set_valid_d;
  tags_t                   set_tag_d;
  ages_t                   set_age_d;
  logic                    unused_offset;

  assign unused_offset = ^add_in[OFFSET_BITS-1:0];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Accessed way becomes MRU; only younger ways age by one
  function automatic ages_t age_touch(input ages_t ages, input logic [AGE_W-1:0] way);
    ages_t res;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == way)          res[w] = '0;
      else if (ages[w] < ages[way])  res[w] = ages[w] + AGE_W'(1);
      else                           res[w] = ages[w];
    end
    return res;
  endfunction

  // Set read, tag compare and victim selection for the latched command
  always_comb begin
    idx_c      = line_q[INDEX_BITS-1:0];
    tag_c      = line_q[LINE_W-1:INDEX_BITS];
    rd_valid_c = valid_q[idx_c];
    rd_tag_c   = tag_q[idx_c];
    rd_age_c   = age_q[idx_c];
    hit_c      = 1'b0;
    hit_way_c  = '0;
    vic_free_c = 1'b0;
    vic_way_c  = '0;
    age_init_c = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      age_init_c[w] = AGE_W'(w);
      if (!hit_c && rd_valid_c[w] && (rd_tag_c[w] == tag_c)) begin
        hit_c     = 1'b1;
        hit_way_c = AGE_W'(w);
      end
      if (!vic_free_c && !rd_valid_c[w]) begin
        vic_free_c = 1'b1;
        vic_way_c  = AGE_W'(w);
      end
    end
    if (!vic_free_c) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (rd_age_c[w] == AGE_W'(WAYS - 1)) vic_way_c = AGE_W'(w);
      end
    end
  end

  // Next-state, set update and registered output values
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cmd_n_d     = cmd_n_q;
    line_d      = line_q;
    rsp_valid_d = 1'b0;
    rsp_hit_d   = 1'b0;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    hits_d      = hits_q;
    misses_d    = misses_q;
    reads_d     = reads_q;
    evict_d     = evict_q;
    set_we_d    = 1'b0;
    set_valid_d = rd_valid_c;
    set_tag_d   = rd_tag_c;
    set_age_d   = rd_age_c;
    case (state_q)
      ST_FLUSH: begin
        ptr_d = ptr_q + INDEX_BITS'(1);
        if (ptr_q == {INDEX_BITS{1'b1}}) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_n_d = n;
          line_d  = add_in[ADDR_W-1:OFFSET_BITS];
          if ((n == 4'd2) || (n == 4'd3)) begin
            state_d = ST_LOOKUP;
          end else if (n == 4'd8) begin
            hits_d   = '0;
            misses_d = '0;
            reads_d  = '0;
            evict_d  = '0;
            ptr_d    = '0;
            state_d  = ST_FLUSH;
          end
        end
      end
      ST_LOOKUP: begin
        if (cmd_n_q == 4'd2) begin
          reads_d = sat_inc(reads_q);
          if (hit_c) begin
            hits_d      = sat_inc(hits_q);
            set_we_d    = 1'b1;
            set_age_d   = age_touch(rd_age_c, hit_way_c);
            rsp_valid_d = 1'b1;
            rsp_hit_d   = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            misses_d   = sat_inc(misses_q);
            mem_req_d  = 1'b1;
            mem_addr_d = line_q;
            state_d    = ST_MISS_REQ;
          end
        end else begin
          if (hit_c) begin
            set_we_d               = 1'b1;
            set_valid_d[hit_way_c] = 1'b0;
            rsp_hit_d              = 1'b1;
          end
          rsp_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_MISS_REQ: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = ST_FILL;
        end
      end
      ST_FILL: begin
        set_we_d               = 1'b1;
        set_valid_d[vic_way_c] = 1'b1;
        set_tag_d[vic_way_c]   = tag_c;
        set_age_d              = age_touch(rd_age_c, vic_way_c);
        if (!vic_free_c) evict_d = sat_inc(evict_q);
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        ptr_d   = '0;
        state_d = ST_FLUSH;
      end
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // Set storage: flush clears one set per cycle, otherwise one set update
  always_ff @(posedge clk) begin
    if (state_q == ST_FLUSH) begin
      valid_q[ptr_q] <= '0;
      age_q[ptr_q]   <= age_init_c;
    end else if (set_we_d) begin
      valid_q[idx_c] <= set_valid_d;
      tag_q[idx_c]   <= set_tag_d;
      age_q[idx_c]   <= set_age_d;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FLUSH;
      ptr_q       <= '0;
      cmd_n_q     <= '0;
      line_q      <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      hits_q      <= '0;
      misses_q    <= '0;
      reads_q     <= '0;
      evict_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cmd_n_q     <= cmd_n_d;
      line_q      <= line_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      hits_q      <= hits_d;
      misses_q    <= misses_d;
      reads_q     <= reads_d;
      evict_q     <= evict_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign hits      = hits_q;
  assign misses    = misses_q;
  assign reads     = reads_q;
  assign evictions = evict_q;

endmodule

// File: doc/ins_cache_nway.md
Name: ins_cache_nway

Overview:
- Parametrised N-way set-associative instruction cache model. It replaces the fixed 2-way instruction cache.
- Sits between the trace-command driver and the next-level cache.
- Adds a valid/ready command handshake, a multi-cycle miss request/acknowledge to the next level, and true LRU for any power-of-2 way count.
- Adds a sequential flush and saturating statistics counters, including evictions.

Parameters:
ADDR_W, 32, byte address width
OFFSET_BITS, 6, log2 line size in bytes
INDEX_BITS, 14, log2 number of sets
WAYS, 4, associativity; power of 2, minimum 2
CNT_W, 32, statistics counter width
(derived) TAG_W = ADDR_W-INDEX_BITS-OFFSET_BITS; AGE_W = log2(WAYS)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
n  in  4  trace command code
add_in  in  ADDR_W  trace address
rsp_valid  out  1  one-cycle pulse: fetch/invalidate completed
rsp_hit  out  1  qualifies rsp_valid: 1 = hit (fetch) or line invalidated
mem_req  out  1  line fill request to next level
mem_addr  out  ADDR_W-OFFSET_BITS  line address, equal to add_in[ADDR_W-1:OFFSET_BITS]
mem_ack  in  1  next level completes the fill
hits, misses, reads, evictions  out  CNT_W each  statistics

Behaviour:
- Address split: tag = add_in[ADDR_W-1:INDEX_BITS+OFFSET_BITS]; index = add_in[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS].
- Per set, per way: valid bit, tag, and AGE_W-bit age. Age 0 = MRU, age WAYS-1 = LRU. The ages of a set always form a permutation of 0..WAYS-1.
- Reset values (rst_n low, asynchronous):
  - cmd_ready=0, rsp_valid=0, rsp_hit=0, mem_req=0, mem_addr=0, all counters=0.
  - FSM enters FLUSH with flush pointer 0.
  - An outstanding miss is abandoned; a late mem_ack is ignored.
- FSM states: FLUSH, IDLE, LOOKUP, MISS_REQ, FILL.
- FLUSH:
  - Clears one set per cycle: all valid=0, age[w]=w. Pointer increments each cycle.
  - Leaves to IDLE after set 2^INDEX_BITS-1 is cleared, i.e. 2^INDEX_BITS cycles. cmd_ready=0 throughout.
- IDLE:
  - cmd_ready=1 only in IDLE. A command is accepted on a rising edge with cmd_valid&cmd_ready; n/add_in are latched there.
  - n=2 (fetch) or n=3 (invalidate) -> LOOKUP.
  - n=8 (reset) -> all counters cleared on that edge, then FLUSH.
  - Any other n (including 9): accepted, no effect, no rsp_valid, stay in IDLE.
- LOOKUP for fetch:
  - reads+1. Hit = any way with valid & tag match.
  - Hit: hits+1, ages update, rsp_valid=1/rsp_hit=1 in the following cycle, return to IDLE (cmd_ready=1 in that same cycle). Hit latency is 1 cycle after accept.
  - Miss: misses+1, go to MISS_REQ.
- LOOKUP for invalidate:
  - Valid & tag match: clear that valid bit, rsp_hit=1.
  - No match: no change, rsp_hit=0.
  - Ages and counters untouched. rsp_valid pulses next cycle; return to IDLE.
- MISS_REQ:
  - mem_req=1 and mem_addr held stable until mem_ack is sampled high. A mem_ack in the first mem_req cycle is valid.
  - mem_ack outside MISS_REQ is ignored. No timeout.
- FILL (1 cycle):
  - Victim = lowest-index invalid way; if none, the way with age WAYS-1, and evictions+1.
  - Write tag, set valid, update ages.
  - rsp_valid=1/rsp_hit=0 in the next cycle; return to IDLE.
- Age update on access to way w: every way with age < age[w] increments; age[w]=0. Ways with larger ages are unchanged.
- Counters saturate at all-ones; no wrap.
- A flush command or rst_n mid-FLUSH restarts the flush at set 0.

Test Plan:
- Release rst_n -> cmd_ready stays 0 for exactly 16384 cycles then rises; all counters 0; mem_req 0.
- Fetch 0x0010_0040 -> mem_req with mem_addr=0x004001; mem_ack after 3 cycles -> rsp_hit=0. Refetch -> rsp_valid 1 cycle after accept, rsp_hit=1. Counters: reads=2, hits=1, misses=1, evictions=0.
- Fetch tags 1..4 at index 1 (0x0010_0040, 0x0020_0040, 0x0030_0040, 0x0040_0040), refetch 0x0010_0040, then fetch 0x0050_0040 -> evictions=1. Fetch 0x0020_0040 -> miss (tag 2 evicted). Fetch 0x0010_0040 -> hit.
- Invalidate 0x0010_0040 -> rsp_hit=1, then fetch -> miss. Invalidate 0x0090_0040 (absent) -> rsp_hit=0, counters unchanged.
- Drop rst_n while mem_req=1 -> mem_req=0 immediately and counters 0. mem_ack pulse during the following FLUSH -> no effect.
- CNT_W=4: 20 fetches of 0x0010_0040 -> reads=15, hits=15, misses=1. Then n=8 -> counters 0 on the accept edge, cmd_ready low for 16384 cycles, next fetch misses.
